// File: rtl/pipe_serializer_pkg.sv
// pipe_serializer_pkg: state encoding private to the pipe_serializer block.
//   No ports; provides state_t (IDLE = no word held, SEND = word being sent).
package pipe_serializer_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/pipe_serializer.sv
// pipe_serializer: stream width-down converter, one RATIO-lane word in, up to RATIO beats out (lane 0 first).
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   valid_in/ready_out  : upstream word handshake (ready_out is combinational)
//   data_in, beats_in   : upstream word and number of lanes to send (0 or >RATIO means RATIO)
//   valid_out/ready_in  : downstream beat handshake
//   data_out, last_out  : current beat and end-of-word flag
module pipe_serializer
    import pipe_serializer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RATIO = 4,
    localparam int BEAT_W = $clog2(RATIO) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [RATIO*WIDTH-1:0] data_in,
    input  logic [BEAT_W-1:0]      beats_in,
    output logic                   ready_out,
    output logic                   valid_out,
    output logic [WIDTH-1:0]       data_out,
    output logic                   last_out,
    input  logic                   ready_in
);
    state_t                 state_q, state_d;
    logic [RATIO*WIDTH-1:0] shreg_q, shreg_d;
    logic [BEAT_W-1:0]      rem_q, rem_d;
    logic [BEAT_W-1:0]      eff_beats;
    logic                   word_xfer, beat_xfer;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
        end
    end
    always_comb begin
        eff_beats = (beats_in == '0 || beats_in > BEAT_W'(RATIO)) ? BEAT_W'(RATIO) : beats_in;
        word_xfer = valid_in & ready_out;
        beat_xfer = valid_out & ready_in;
        state_d   = state_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        // A word can only be taken while idle or on the last beat, so a reload
        // always supersedes the shift/clear of the finishing word.
        if (word_xfer) begin
            state_d = SEND;
            shreg_d = data_in;
            rem_d   = eff_beats;
        end else if (beat_xfer) begin
            state_d = (rem_q > BEAT_W'(1)) ? SEND : IDLE;
            shreg_d = (rem_q > BEAT_W'(1)) ? shreg_q >> WIDTH : '0;
            rem_d   = (rem_q > BEAT_W'(1)) ? rem_q - BEAT_W'(1) : '0;
        end
    end
    always_comb begin
        valid_out = (state_q == SEND);
        data_out  = shreg_q[WIDTH-1:0];
        last_out  = (state_q == SEND) && (rem_q == BEAT_W'(1));
        ready_out = ~rst & ((state_q == IDLE) | (last_out & ready_in));
    end
endmodule

// File: tb/tb_pipe_serializer.sv
// tb_pipe_serializer: directed and random checks of pipe_serializer against a beat-queue model.
module tb_pipe_serializer;
    localparam int WIDTH = 32;
    localparam int RATIO = 4;
    localparam int BEAT_W = $clog2(RATIO) + 1;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   valid_in = 1'b0;
    logic [RATIO*WIDTH-1:0] data_in = '0;
    logic [BEAT_W-1:0]      beats_in = '0;
    logic                   ready_in = 1'b0;
    logic                   ready_out, valid_out, last_out;
    logic [WIDTH-1:0]       data_out;

    int    tests = 0;
    int    fails = 0;
    beat_t q[$];
    logic  word_acc;

    pipe_serializer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .beats_in(beats_in),
        .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
        .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model at the edge.
    task automatic tick();
        logic exp_ready, beat, word;
        int   eff;
        #1;
        exp_ready = !rst && (q.size() == 0 || (q[0].l && ready_in));
        chk("ready_out", 32'(ready_out), 32'(exp_ready));
        chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
        chk("data_out", data_out, q.size() != 0 ? q[0].d : '0);
        chk("last_out", 32'(last_out), q.size() != 0 ? 32'(q[0].l) : 32'd0);
        beat = q.size() != 0 && ready_in;
        word = valid_in && exp_ready;
        eff = (beats_in == 0 || beats_in > RATIO) ? RATIO : int'(beats_in);
        @(posedge clk);
        word_acc = word;
        if (rst) q.delete();
        else begin
            if (beat) void'(q.pop_front());
            if (word)
                for (int i = 0; i < eff; i++) q.push_back('{data_in[i*WIDTH +: WIDTH], i == eff - 1});
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [RATIO*WIDTH-1:0] d, input int b);
        int n = 0;
        valid_in = 1'b1;
        data_in  = d;
        beats_in = BEAT_W'(b);
        word_acc = 1'b0;
        while (!word_acc && n < 50) begin
            tick();
            n++;
        end
        tests++;
        assert (word_acc) else begin
            fails++;
            $error("FAIL accept_timeout: got %0d expected 1", word_acc);
        end
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout: got %0d expected 0", q.size());
        end
        tick();
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        // Full word streaming.
        ready_in = 1'b1;
        send_word(128'h44444444_33333333_22222222_11111111, 4);
        chk("full_b0", data_out, 32'h11111111);
        chk("full_b0_last", 32'(last_out), 32'd0);
        tick();
        tick();
        tick();
        chk("full_b3", data_out, 32'h44444444);
        chk("full_b3_last", 32'(last_out), 32'd1);
        drain();
        // Back-to-back: two-beat word then one-beat word with no bubble.
        send_word(128'h0_0_bbbbbbbb_aaaaaaaa, 2);
        send_word(128'h0_0_0_cccccccc, 1);
        chk("b2b_third", data_out, 32'hcccccccc);
        chk("b2b_third_last", 32'(last_out), 32'd1);
        drain();
        // Backpressure after beat 1.
        send_word(128'hd4d4d4d4_d3d3d3d3_d2d2d2d2_d1d1d1d1, 4);
        tick();
        ready_in = 1'b0;
        repeat (5) tick();
        chk("bp_hold", data_out, 32'hd2d2d2d2);
        ready_in = 1'b1;
        drain();
        // Partial and out-of-range beat counts.
        send_word(128'h4_3_2_e1e1e1e1, 1);
        chk("one_last", 32'(last_out), 32'd1);
        drain();
        send_word(128'hf4_f3_f2_f1, 0);
        drain();
        send_word(128'h74_73_72_71, 7);
        drain();
        // Reset mid-word after beat 2 of 4.
        send_word(128'h94_93_92_91, 4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(valid_out), 32'd0);
        chk("rst_mid_data", data_out, 32'd0);
        tick();
        send_word(128'ha4_a3_a2_a1, 3);
        drain();
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            beats_in = BEAT_W'($urandom_range(0, 7));
            ready_in = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
        end
        valid_in = 1'b0;
        rst      = 1'b0;
        ready_in = 1'b1;
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
